// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage buffers.
// Payload layout of the ID/EX stage: five 32-bit fields.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int FIELD_W = 32;
    localparam int ID_EX_W = 5 * FIELD_W;

    // Bit offsets of each field inside the ID/EX payload.
    localparam int INS = 0;
    localparam int PC8 = 32;
    localparam int RD1 = 64;
    localparam int RD2 = 96;
    localparam int EXT = 128;

    // PC+8 field resets to the boot vector so a bubble carries a sane PC.
    localparam logic [ID_EX_W-1:0] PIPE_RST_ID_EX = {96'h0, 32'h0000_3000, 32'h0};
    localparam logic [ID_EX_W-1:0] PIPE_RST_EX_MEM = '0;
    localparam logic [ID_EX_W-1:0] PIPE_RST_MEM_WB = '0;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with enable and synchronous clear.
module pipe_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register, optionally with a skid entry so that
// in_ready does not depend combinationally on out_ready.
//
//   state | meaning
//   EMPTY | no payload held, out_valid low
//   HALF  | main register holds the next payload
//   FULL  | main and skid both hold payloads, upstream is stalled
module pipe_stage_buf import pipe_pkg::*; #(
    parameter int                 DATA_W  = 160,
    parameter logic [DATA_W-1:0]  RST_VAL = DATA_W'(PIPE_RST_ID_EX),
    parameter bit                 SKID    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       stall_cnt
);

    logic accept;
    logic deliver;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    generate
        if (SKID) begin : g_skid
            pipe_state_t       state;
            logic [DATA_W-1:0] main_q;
            logic [DATA_W-1:0] skid_q;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    state  <= EMPTY;
                    main_q <= RST_VAL;
                    skid_q <= RST_VAL;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (accept) begin
                                state  <= HALF;
                                main_q <= in_data;
                            end
                        end
                        HALF: begin
                            if (accept && deliver) begin
                                main_q <= in_data;
                            end else if (accept) begin
                                state  <= FULL;
                                skid_q <= in_data;
                            end else if (deliver) begin
                                state <= EMPTY;
                            end
                        end
                        FULL: begin
                            if (deliver) begin
                                state  <= HALF;
                                main_q <= skid_q;
                            end
                        end
                        default: state <= EMPTY;
                    endcase
                end
            end

            // Depends only on the state register, never on out_ready.
            assign in_ready  = (state != FULL) && !flush && !rst;
            assign out_valid = (state != EMPTY);
            assign out_data  = main_q;
        end else begin : g_single
            logic              valid_q;
            logic [DATA_W-1:0] main_q;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    valid_q <= 1'b0;
                    main_q  <= RST_VAL;
                end else if (accept) begin
                    valid_q <= 1'b1;
                    main_q  <= in_data;
                end else if (deliver) begin
                    valid_q <= 1'b0;
                end
            end

            assign in_ready  = (!valid_q || out_ready) && !flush && !rst;
            assign out_valid = valid_q;
            assign out_data  = main_q;
        end
    endgenerate

    pipe_sat_cnt #(.W(32)) u_stall (
        .clk (clk),
        .clr (rst),
        .en  (out_valid && !out_ready),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: dut0 uses the skid buffer, dut1 the
// single register; each is exercised in turn with the same directed scenarios.
module tb_pipe_stage_buf;

    localparam logic [159:0] EXP_RST = {96'h0, 32'h0000_3000, 32'h0};

    logic         clk = 1'b0;
    logic [1:0]   rst = 2'b11;
    logic [1:0]   flush = 2'b00;
    logic [1:0]   in_valid = 2'b00;
    logic [1:0]   out_ready = 2'b00;
    logic [159:0] in_data [2];

    logic         in_ready0, in_ready1, out_valid0, out_valid1;
    logic [159:0] out_data0, out_data1;
    logic [31:0]  stall0, stall1;

    logic [159:0] exp_q0 [$];
    logic [159:0] exp_q1 [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.SKID(1'b1)) dut0 (
        .clk(clk), .rst(rst[0]), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready0), .in_data(in_data[0]),
        .out_valid(out_valid0), .out_ready(out_ready[0]), .out_data(out_data0),
        .stall_cnt(stall0)
    );

    pipe_stage_buf #(.SKID(1'b0)) dut1 (
        .clk(clk), .rst(rst[1]), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready1), .in_data(in_data[1]),
        .out_valid(out_valid1), .out_ready(out_ready[1]), .out_data(out_data1),
        .stall_cnt(stall1)
    );

    function automatic logic ir(int d);
        return (d == 0) ? in_ready0 : in_ready1;
    endfunction
    function automatic logic ov(int d);
        return (d == 0) ? out_valid0 : out_valid1;
    endfunction
    function automatic logic [159:0] od(int d);
        return (d == 0) ? out_data0 : out_data1;
    endfunction
    function automatic logic [31:0] sc(int d);
        return (d == 0) ? stall0 : stall1;
    endfunction

    task automatic chk(int d, string name, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [dut%0d]: got %0h, expected %0h", name, d, act, exp);
        end
    endtask

    task automatic sb_pop(int d, logic [159:0] act);
        logic [159:0] exp;
        checks++;
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            errors++;
            $display("FAIL sb_unexpected [dut%0d]: got %0h, expected no output", d, act);
        end else begin
            exp = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL sb_data [dut%0d]: got %0h, expected %0h", d, act, exp);
            end
        end
    endtask

    // Monitor: every completed delivery is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst[0] && out_valid0 && out_ready[0]) sb_pop(0, out_data0);
        if (!rst[1] && out_valid1 && out_ready[1]) sb_pop(1, out_data1);
    end

    // One clock cycle; an accepted payload is queued as the expected output.
    task automatic step(int d);
        @(negedge clk);
        if (!rst[d] && !flush[d] && in_valid[d] && ir(d)) begin
            if (d == 0) exp_q0.push_back(in_data[d]);
            else        exp_q1.push_back(in_data[d]);
        end
        @(posedge clk);
        if (rst[d] || flush[d]) begin
            if (d == 0) exp_q0.delete();
            else        exp_q1.delete();
        end
        #1;
    endtask

    task automatic do_reset(int d);
        rst[d] = 1'b1; flush[d] = 1'b0; out_ready[d] = 1'b1;
        in_valid[d] = 1'b1; in_data[d] = 160'hDEAD;
        #1 chk(d, "rst_in_ready_c0", ir(d), 0);
        step(d);
        chk(d, "rst_in_ready_c1", ir(d), 0);
        step(d);
        rst[d] = 1'b0; in_valid[d] = 1'b0;
        #1;
        chk(d, "rst_out_valid", ov(d), 0);
        chk(d, "rst_out_data", od(d), EXP_RST);
        chk(d, "rst_pc8_field", od(d)[63:32], 32'h0000_3000);
        chk(d, "rst_stall_cnt", sc(d), 0);
    endtask

    task automatic t_stream(int d);
        do_reset(d);
        out_ready[d] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid[d] = 1'b1; in_data[d] = 160'(i);
            #1 chk(d, "stream_in_ready", ir(d), 1);
            step(d);
            chk(d, "stream_latency_valid", ov(d), 1);
            chk(d, "stream_latency_data", od(d), 160'(i));
        end
        in_valid[d] = 1'b0;
        step(d);
        chk(d, "stream_drained", ov(d), 0);
        step(d);
        chk(d, "empty_holds_data", od(d), 160'h8);
        chk(d, "stream_no_stall", sc(d), 0);
    endtask

    task automatic t_backpressure(int d);
        do_reset(d);
        out_ready[d] = 1'b0;
        in_valid[d] = 1'b1; in_data[d] = 160'hA;
        #1 chk(d, "bp_ready_a", ir(d), 1);
        step(d);
        in_data[d] = 160'hB;
        if (d == 0) begin
            #1 chk(d, "bp_ready_b", ir(d), 1);
            step(d);
            in_data[d] = 160'hC;
            #1 chk(d, "bp_full_ready", ir(d), 0);
            chk(d, "bp_full_head", od(d), 160'hA);
            chk(d, "bp_stall_1", sc(d), 1);
            step(d);
            chk(d, "bp_stall_2", sc(d), 2);
            out_ready[d] = 1'b1;
            #1 chk(d, "bp_no_comb_ready", ir(d), 0);
            step(d);
            #1 chk(d, "bp_half_ready", ir(d), 1);
            step(d);
            in_valid[d] = 1'b0;
            step(d);
        end else begin
            #1 chk(d, "bp_held_ready", ir(d), 0);
            step(d);
            chk(d, "bp_stall_1", sc(d), 1);
            out_ready[d] = 1'b1;
            #1 chk(d, "bp_ready_follows", ir(d), 1);
            step(d);
            in_data[d] = 160'hC;
            #1 chk(d, "bp_ready_c", ir(d), 1);
            step(d);
            in_valid[d] = 1'b0; out_ready[d] = 1'b0;
            #1 chk(d, "bp_ready_drops", ir(d), 0);
            step(d);
            out_ready[d] = 1'b1;
            step(d);
        end
        step(d);
        chk(d, "bp_drained", ov(d), 0);
        chk(d, "bp_stall_final", sc(d), 2);
    endtask

    task automatic t_flush(int d);
        do_reset(d);
        out_ready[d] = 1'b0;
        in_valid[d] = 1'b1; in_data[d] = 160'h11;
        step(d);
        in_data[d] = 160'h22;
        step(d);
        in_data[d] = 160'h33; out_ready[d] = 1'b1; flush[d] = 1'b1;
        #1 chk(d, "flush_in_ready", ir(d), 0);
        step(d);
        flush[d] = 1'b0; in_valid[d] = 1'b0;
        chk(d, "flush_out_valid", ov(d), 0);
        chk(d, "flush_out_data", od(d), EXP_RST);
        chk(d, "flush_stall_kept", sc(d), 1);
        step(d);
        step(d);
        chk(d, "flush_stays_empty", ov(d), 0);
        in_valid[d] = 1'b1; in_data[d] = 160'h44;
        step(d);
        in_valid[d] = 1'b0;
        chk(d, "flush_next_data", od(d), 160'h44);
        step(d);
    endtask

    task automatic t_saturate();
        do_reset(0);
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1; in_data[0] = 160'h55;
        step(0);
        in_data[0] = 160'h66;
        step(0);
        in_valid[0] = 1'b0;
        force dut0.u_stall.cnt_q = 32'hFFFF_FFFE;
        #1 release dut0.u_stall.cnt_q;
        step(0);
        chk(0, "sat_reach_max", sc(0), 32'hFFFF_FFFF);
        step(0);
        step(0);
        chk(0, "sat_hold_max", sc(0), 32'hFFFF_FFFF);
        // Reset while FULL: both held payloads must vanish.
        do_reset(0);
        out_ready[0] = 1'b1;
        step(0);
        step(0);
        chk(0, "midreset_empty", ov(0), 0);
    endtask

    initial begin
        in_data[0] = '0;
        in_data[1] = '0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            t_stream(d);
            t_backpressure(d);
            t_flush(d);
            rst[d] = 1'b1;
        end
        t_saturate();
        chk(0, "sb_leftover", 160'(exp_q0.size()), 0);
        chk(1, "sb_leftover", 160'(exp_q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
